aes_bridge_mode_ctrl: RTL and testbench
=======================================

# aes_bridge_mode_ctrl

Mode controller for the AES UART bridge datapath. It owns the working-mode configuration (`wm`, `ee`, `de`) that drives the bridge, and it generates the bridge's end-of-packet `idle` from an inter-byte gap timer. Mode changes requested by the register block are applied only after intake is gated and in-flight 128-bit blocks have drained, so a switch never splits a block. It sits between the CSR block and the regs/AES bridge and its cipher/invcipher cores.

## Interface
Parameters:
- `IDLE_CYCLES`, default 1000: inter-byte gap in clk cycles before `idle` asserts; range 1..65535.
- `DRAIN_TIMEOUT`, default 4096: maximum cycles spent in DRAIN before the mode is force-applied.
- `SETTLE_CYCLES`, default 2: cycles gating stays on after a new mode is applied; range 1..15.
- `OUT_W`, default 4: width of the outstanding-block counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  mode change request.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_wm`  in  2  requested working mode.
- `req_ee`  in  1  requested encrypt-enable.
- `req_de`  in  1  requested decrypt-enable.
- `rx_beat`  in  1  8-bit beat accepted from select (valid&ready).
- `blk_start`  in  1  1-cycle pulse: a 128-bit block entered the AES path.
- `blk_end`  in  1  1-cycle pulse: a block fully left the AES path.
- `err_clr`  in  1  clears `err`.
- `wm`  out  2  applied working mode.
- `ee`  out  1  applied encrypt-enable.
- `de`  out  1  applied decrypt-enable.
- `idle`  out  1  end-of-packet indication to the bridge.
- `gate_in`  out  1  top level forces input tready low while high.
- `busy`  out  1  mode change in progress.
- `outstanding`  out  OUT_W  in-flight block count.
- `err`  out  2  sticky errors. Bit 0 = drain timeout; bit 1 = counter overflow or underflow.

## Operation
States are RUN, DRAIN and SETTLE. `busy = (state != RUN)`. `req_ready = (state == RUN)`.

RUN:
- An accepted request whose {wm,ee,de} equals the applied value is a no-op.
- Any other accepted request latches the pending value and moves to DRAIN. The DRAIN timer is cleared.

DRAIN:
- `gate_in` = 1.
- The exit condition is `partial == 0 && outstanding == 0 && !blk_start && !blk_end`. When it is met, the pending value is registered into wm/ee/de, `partial` and the idle timer are cleared, and the state moves to SETTLE.
- If the timer reaches DRAIN_TIMEOUT first, `err[0]` is set, the mode is applied the same way, and `outstanding` is forced to 0.

SETTLE:
- `gate_in` = 1 for SETTLE_CYCLES cycles, then the state returns to RUN.

`partial` (4-bit):
- Counts `rx_beat` modulo 16 while `wm == 01`.
- Cleared on `blk_start`.
- Held at 0 in other modes.

`outstanding`:
- +1 on `blk_start`, −1 on `blk_end`; unchanged when both pulse in the same cycle.
- At max with a lone start: saturate and set `err[1]`.
- At 0 with a lone end: stay at 0 and set `err[1]`.

Idle timer (16-bit):
- `rx_beat` clears it to 0.
- Otherwise it increments, saturating at IDLE_CYCLES.
- `idle = (timer == IDLE_CYCLES) || (state == DRAIN && wm == 01 && partial != 0)`. The second term flushes a partial block.

`err`:
- Bits are sticky.
- `err_clr` clears them. A new error in the same cycle as `err_clr` wins.

## Timing
- Reset values: state RUN, wm=00, ee=0, de=0, gate_in=0, busy=0, req_ready=1, idle=0, timer=0, partial=0, outstanding=0, err=00.
- A request accepted at cycle N gives `busy` = 1 and `gate_in` = 1 from cycle N+1.
- If DRAIN's exit condition holds at cycle M, the new wm/ee/de are visible at M+1.
- `gate_in` and `busy` are low from M+1+SETTLE_CYCLES.
- Fastest switch (already drained): new mode at N+2, `gate_in` low at N+2+SETTLE_CYCLES.
- `idle` is combinational from registered state. An `rx_beat` at cycle K makes `idle` low at K+1.
- A request presented while `busy` is not accepted and must be held by the source.
- Reset mid-DRAIN: everything returns to reset values, the pending request is dropped and wm=00.

## Test plan
- Reset, then idle the bus → wm=00, ee=0, de=0, busy=0, req_ready=1; idle rises exactly IDLE_CYCLES cycles after reset.
- req wm=01 with outstanding=0 at cycle N → wm=01 at N+2; gate_in high N+1..N+3; busy low at N+4 (SETTLE_CYCLES=2).
- In wm=01, send 5 rx_beat, then req wm=10 → idle forced high in DRAIN; blk_start, then blk_end 10 cycles later; wm=10 one cycle after blk_end.
- blk_start and blk_end in the same cycle with outstanding=3 → outstanding stays 3, err=00; blk_end at outstanding=0 → err[1]=1, then err_clr → 00.
- DRAIN_TIMEOUT=16 with outstanding stuck at 2 → err[0]=1 after 16 DRAIN cycles; mode applied; outstanding=0.
- Same-mode request → accepted, busy never rises; assert rst during DRAIN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/aes_bridge_mode_ctrl.sv
// Mode controller for the AES UART bridge: owns the applied wm/ee/de, drains
// in-flight blocks before a mode switch, and generates the end-of-packet idle.
module aes_bridge_mode_ctrl #(
    parameter int IDLE_CYCLES   = 1000,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int SETTLE_CYCLES = 2,
    parameter int OUT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_wm_i,
    input  logic             req_ee_i,
    input  logic             req_de_i,
    input  logic             rx_beat_i,
    input  logic             blk_start_i,
    input  logic             blk_end_i,
    input  logic             err_clr_i,
    output logic [1:0]       wm_o,
    output logic             ee_o,
    output logic             de_o,
    output logic             idle_o,
    output logic             gate_in_o,
    output logic             busy_o,
    output logic [OUT_W-1:0] outstanding_o,
    output logic [1:0]       err_o
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [15:0]      IDLE_MAX  = 16'(IDLE_CYCLES);
    localparam logic [DW-1:0]    DRAIN_END = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]       SETTLE_END = 4'(SETTLE_CYCLES - 1);
    localparam logic [OUT_W-1:0] OUT_MAX   = {OUT_W{1'b1}};

    typedef enum logic [1:0] {RUN, DRAIN, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       wm_q, wm_d, pendWm_q, pendWm_d;
    logic             ee_q, ee_d, de_q, de_d;
    logic             pendEe_q, pendEe_d, pendDe_q, pendDe_d;
    logic [DW-1:0]    drainCnt_q, drainCnt_d;
    logic [3:0]       settleCnt_q, settleCnt_d;
    logic [3:0]       partial_q, partial_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [15:0]      timer_q, timer_d;
    logic [1:0]       err_q, err_d;
    logic             gate_q, gate_d, busy_q, busy_d, ready_q, ready_d;
    logic             applyNow, timeoutNow, cntErr, exitCond;

    assign exitCond = (partial_q == 4'd0) && (outstanding_q == '0) && !blk_start_i && !blk_end_i;

    always_comb begin
        state_d       = state_q;
        wm_d          = wm_q;
        ee_d          = ee_q;
        de_d          = de_q;
        pendWm_d      = pendWm_q;
        pendEe_d      = pendEe_q;
        pendDe_d      = pendDe_q;
        drainCnt_d    = drainCnt_q;
        settleCnt_d   = settleCnt_q;
        applyNow      = 1'b0;
        timeoutNow    = 1'b0;
        cntErr        = 1'b0;
        outstanding_d = outstanding_q;
        partial_d     = partial_q;
        timer_d       = timer_q;

        case (state_q)
            RUN: begin
                if (req_valid_i && ({req_wm_i, req_ee_i, req_de_i} != {wm_q, ee_q, de_q})) begin
                    pendWm_d   = req_wm_i;
                    pendEe_d   = req_ee_i;
                    pendDe_d   = req_de_i;
                    drainCnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (exitCond) begin
                    applyNow = 1'b1;
                end else if (drainCnt_q == DRAIN_END) begin
                    applyNow   = 1'b1;
                    timeoutNow = 1'b1;
                end else begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (settleCnt_q == SETTLE_END) begin
                    state_d = RUN;
                end else begin
                    settleCnt_d = settleCnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (applyNow) begin
            wm_d        = pendWm_q;
            ee_d        = pendEe_q;
            de_d        = pendDe_q;
            settleCnt_d = 4'd0;
            state_d     = SETTLE;
        end

        // Simultaneous start and end leave the count alone; lone pulses saturate at the rails.
        if (blk_start_i && !blk_end_i) begin
            if (outstanding_q == OUT_MAX) cntErr = 1'b1;
            else outstanding_d = outstanding_q + 1'b1;
        end else if (blk_end_i && !blk_start_i) begin
            if (outstanding_q == '0) cntErr = 1'b1;
            else outstanding_d = outstanding_q - 1'b1;
        end
        if (timeoutNow) outstanding_d = '0;

        if (applyNow || wm_q != 2'b01 || blk_start_i) partial_d = 4'd0;
        else if (rx_beat_i) partial_d = partial_q + 4'd1;

        if (rx_beat_i || applyNow) timer_d = 16'd0;
        else if (timer_q != IDLE_MAX) timer_d = timer_q + 16'd1;

        err_d  = (err_clr_i ? 2'b00 : err_q) | {cntErr, timeoutNow};
        gate_d  = (state_d != RUN);
        busy_d  = (state_d != RUN);
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wm_q          <= 2'b00;
            ee_q          <= 1'b0;
            de_q          <= 1'b0;
            pendWm_q      <= 2'b00;
            pendEe_q      <= 1'b0;
            pendDe_q      <= 1'b0;
            drainCnt_q    <= '0;
            settleCnt_q   <= 4'd0;
            partial_q     <= 4'd0;
            outstanding_q <= '0;
            timer_q       <= 16'd0;
            err_q         <= 2'b00;
            gate_q        <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            wm_q          <= wm_d;
            ee_q          <= ee_d;
            de_q          <= de_d;
            pendWm_q      <= pendWm_d;
            pendEe_q      <= pendEe_d;
            pendDe_q      <= pendDe_d;
            drainCnt_q    <= drainCnt_d;
            settleCnt_q   <= settleCnt_d;
            partial_q     <= partial_d;
            outstanding_q <= outstanding_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            gate_q        <= gate_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    // A pending partial block in mode 01 must be flushed, so DRAIN forces idle.
    assign idle_o = (timer_q == IDLE_MAX) ||
                    (state_q == DRAIN && wm_q == 2'b01 && partial_q != 4'd0);

    assign wm_o          = wm_q;
    assign ee_o          = ee_q;
    assign de_o          = de_q;
    assign gate_in_o     = gate_q;
    assign busy_o        = busy_q;
    assign req_ready_o   = ready_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_aes_bridge_mode_ctrl.sv
// Directed bench for aes_bridge_mode_ctrl: counter vectors from a table plus
// hand-written sequences for mode switches, drain timeout and reset.
module tb_aes_bridge_mode_ctrl;

    localparam int IDLE_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [1:0] req_wm = 2'b00;
    logic       req_ee = 1'b0, req_de = 1'b0;
    logic       rx_beat = 1'b0, blk_start = 1'b0, blk_end = 1'b0, err_clr = 1'b0;
    logic [1:0] wm, err;
    logic       ee, de, idle, gate_in, busy;
    logic [3:0] outstanding;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clr;
        logic [3:0] expOut;
        logic [1:0] expErr;
    } vec_t;

    vec_t vecs[10];

    aes_bridge_mode_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES), .DRAIN_TIMEOUT(16), .SETTLE_CYCLES(2), .OUT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_wm_i(req_wm), .req_ee_i(req_ee), .req_de_i(req_de),
        .rx_beat_i(rx_beat), .blk_start_i(blk_start), .blk_end_i(blk_end),
        .err_clr_i(err_clr),
        .wm_o(wm), .ee_o(ee), .de_o(de), .idle_o(idle), .gate_in_o(gate_in),
        .busy_o(busy), .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic c);
        blk_start = s;
        blk_end   = e;
        err_clr   = c;
        tick();
        blk_start = 1'b0;
        blk_end   = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic request(input logic [1:0] w, input logic e, input logic d);
        req_valid = 1'b1;
        req_wm    = w;
        req_ee    = e;
        req_de    = d;
        checkOutput("req_ready_at_accept", 16'(req_ready), 16'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd2, 2'b00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'd3, 2'b00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd3, 2'b00};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd2, 2'b00};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4'd1, 2'b00};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 2'b00};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 4'd0, 2'b10};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 4'd0, 2'b00};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 4'd0, 2'b00};

        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_wm", 16'(wm), 16'd0);
        checkOutput("rst_ee_de", 16'({ee, de}), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_gate", 16'(gate_in), 16'd0);
        checkOutput("rst_ready", 16'(req_ready), 16'd1);
        checkOutput("rst_idle", 16'(idle), 16'd0);
        checkOutput("rst_out", 16'(outstanding), 16'd0);
        checkOutput("rst_err", 16'(err), 16'd0);

        for (int i = 0; i < IDLE_CYCLES - 1; i++) tick();
        checkOutput("idle_before_gap", 16'(idle), 16'd0);
        tick();
        checkOutput("idle_after_gap", 16'(idle), 16'd1);
        rx_beat = 1'b1;
        tick();
        rx_beat = 1'b0;
        checkOutput("idle_drop_on_beat", 16'(idle), 16'd0);

        // Fastest switch to wm=01 with nothing in flight.
        request(2'b01, 1'b1, 1'b0);
        checkOutput("fast_n1_busy", 16'(busy), 16'd1);
        checkOutput("fast_n1_gate", 16'(gate_in), 16'd1);
        checkOutput("fast_n1_ready", 16'(req_ready), 16'd0);
        checkOutput("fast_n1_wm", 16'(wm), 16'd0);
        tick();
        checkOutput("fast_n2_mode", 16'({wm, ee, de}), 16'b0110);
        checkOutput("fast_n2_gate", 16'(gate_in), 16'd1);
        tick();
        checkOutput("fast_n3_gate", 16'(gate_in), 16'd1);
        tick();
        checkOutput("fast_n4_gate", 16'(gate_in), 16'd0);
        checkOutput("fast_n4_busy", 16'(busy), 16'd0);

        // Partial block in wm=01 forces idle during DRAIN, then a block drains.
        rx_beat = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rx_beat = 1'b0;
        checkOutput("part_idle_run", 16'(idle), 16'd0);
        request(2'b10, 1'b0, 1'b1);
        checkOutput("part_idle_drain", 16'(idle), 16'd1);
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        checkOutput("part_out_1", 16'(outstanding), 16'd1);
        checkOutput("part_idle_cleared", 16'(idle), 16'd0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("part_wm_held", 16'(wm), 16'd1);
        blk_end = 1'b1;
        tick();
        blk_end = 1'b0;
        checkOutput("part_wm_after_end", 16'(wm), 16'd1);
        checkOutput("part_out_0", 16'(outstanding), 16'd0);
        tick();
        checkOutput("part_mode_applied", 16'({wm, ee, de}), 16'b1001);
        tick();
        tick();
        checkOutput("part_busy_done", 16'(busy), 16'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clr);
            checkOutput($sformatf("vec%0d_out", i), 16'(outstanding), 16'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d_err", i), 16'(err), 16'(vecs[i].expErr));
        end

        // Overflow at the counter maximum; a new error beats err_clr.
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_full", 16'(outstanding), 16'd15);
        checkOutput("ovf_full_err", 16'(err), 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_sat", 16'(outstanding), 16'd15);
        checkOutput("ovf_err", 16'(err), 16'b10);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ovf_clr_loses", 16'(err), 16'b10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("ovf_clr", 16'(err), 16'd0);
        for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ovf_down", 16'(outstanding), 16'd2);

        // Drain timeout with two blocks stuck in flight.
        request(2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("to_d15_err", 16'(err), 16'd0);
        checkOutput("to_d15_wm", 16'(wm), 16'b10);
        tick();
        checkOutput("to_err", 16'(err), 16'b01);
        checkOutput("to_mode", 16'({wm, ee, de}), 16'b1111);
        checkOutput("to_out", 16'(outstanding), 16'd0);
        checkOutput("to_busy_settle", 16'(busy), 16'd1);
        tick();
        tick();
        checkOutput("to_busy_done", 16'(busy), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("to_err_clr", 16'(err), 16'd0);

        // Same-mode request is a no-op.
        request(2'b11, 1'b1, 1'b1);
        checkOutput("same_busy", 16'(busy), 16'd0);
        checkOutput("same_gate", 16'(gate_in), 16'd0);
        tick();
        checkOutput("same_busy2", 16'(busy), 16'd0);

        // Reset in the middle of DRAIN drops the pending request.
        applyStimulus(1'b1, 1'b0, 1'b0);
        request(2'b01, 1'b0, 1'b0);
        tick();
        checkOutput("rd_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rd_mode", 16'({wm, ee, de}), 16'd0);
        checkOutput("rd_busy_low", 16'(busy), 16'd0);
        checkOutput("rd_gate", 16'(gate_in), 16'd0);
        checkOutput("rd_ready", 16'(req_ready), 16'd1);
        checkOutput("rd_out", 16'(outstanding), 16'd0);
        checkOutput("rd_idle", 16'(idle), 16'd0);
        checkOutput("rd_err", 16'(err), 16'd0);
        tick();
        checkOutput("rd_no_resume", 16'({busy, wm}), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
